// File: rtl/rr_token_arbiter.sv
// rr_token_arbiter: N-channel round-robin arbiter with four-phase req/ack.
// Lookahead or one-step token scan, optional hold timeout with revocation.
module rr_token_arbiter #(
  parameter int N = 4,
  parameter int LOOKAHEAD = 1,
  parameter int TIMEOUT = 0,
  localparam int PTR_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     ack,
  output logic [PTR_W-1:0] sel,
  output logic             sel_valid,
  output logic [N-1:0]     revoke
);

  localparam int CLOG_T = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (TIMEOUT > 0 && CLOG_T > 1) ? CLOG_T : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W:0] NW = (PTR_W + 1)'(N);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    READY   = 2'd1,
    BUSY    = 2'd2,
    REVOKED = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic [PTR_W-1:0] g, g_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic             hit;
  logic [PTR_W-1:0] hit_idx;

  logic [N-1:0]     ack_n;
  logic [N-1:0]     revoke_n;
  logic [PTR_W-1:0] sel_n;
  logic             sel_valid_n;

  // "+1" must wrap at N, not at 2^PTR_W, so odd channel counts work.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] x);
    return (x == PTR_W'(N - 1)) ? '0 : x + 1'b1;
  endfunction

  // Circular search from ptr; walking backwards leaves the first hit.
  always_comb begin
    logic [PTR_W:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (req[idx[PTR_W-1:0]]) begin
        hit     = 1'b1;
        hit_idx = idx[PTR_W-1:0];
      end
    end
  end

  // State and token registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      ptr   <= '0;
      g     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      g     <= g_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: scan, grant, hold with optional timeout, wait after revoke.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    g_n     = g;
    cnt_n   = cnt;
    unique case (state)
      SCAN: begin
        if (LOOKAHEAD != 0) begin
          if (hit) begin
            g_n     = hit_idx;
            state_n = READY;
          end
        end else if (req[ptr]) begin
          g_n     = ptr;
          state_n = READY;
        end else begin
          ptr_n = wrap_inc(ptr);
        end
      end
      READY: begin
        cnt_n   = '0;
        state_n = BUSY;
      end
      BUSY: begin
        if (!req[g]) begin
          ptr_n   = wrap_inc(g);
          state_n = SCAN;
        end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
          state_n = REVOKED;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      REVOKED: begin
        if (!req[g]) begin
          ptr_n   = wrap_inc(g);
          state_n = SCAN;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // Output decode from the upcoming state so outputs register with it.
  always_comb begin
    ack_n       = '0;
    revoke_n    = '0;
    if (state_n == BUSY) ack_n[g_n] = 1'b1;
    if (state == BUSY && state_n == REVOKED) revoke_n[g] = 1'b1;
    sel_valid_n = (state_n != SCAN);
    sel_n       = g_n;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= '0;
      revoke    <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
    end else begin
      ack       <= ack_n;
      revoke    <= revoke_n;
      sel       <= sel_n;
      sel_valid <= sel_valid_n;
    end
  end

endmodule

// File: tb/tb_rr_token_arbiter.sv
// tb_rr_token_arbiter: directed checks on four arbiter configurations.
// Expected values are worked out by hand from the handshake timing.
module tb_rr_token_arbiter;

  logic clk;
  logic rst_n;

  logic [3:0] req_a, ack_a, rev_a;
  logic [1:0] sel_a;
  logic       sv_a;

  logic [2:0] req_b, ack_b, rev_b;
  logic [1:0] sel_b;
  logic       sv_b;

  logic [3:0] req_c, ack_c, rev_c;
  logic [1:0] sel_c;
  logic       sv_c;

  logic [3:0] req_d, ack_d, rev_d;
  logic [1:0] sel_d;
  logic       sv_d;

  int tests;
  int fails;

  rr_token_arbiter #(.N(4), .LOOKAHEAD(1), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a),
    .sel(sel_a), .sel_valid(sv_a), .revoke(rev_a)
  );

  rr_token_arbiter #(.N(3), .LOOKAHEAD(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ack(ack_b),
    .sel(sel_b), .sel_valid(sv_b), .revoke(rev_b)
  );

  rr_token_arbiter #(.N(4), .LOOKAHEAD(0), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .ack(ack_c),
    .sel(sel_c), .sel_valid(sv_c), .revoke(rev_c)
  );

  rr_token_arbiter #(.N(4), .LOOKAHEAD(1), .TIMEOUT(4)) dut_d (
    .clk(clk), .rst_n(rst_n), .req(req_d), .ack(ack_d),
    .sel(sel_d), .sel_valid(sv_d), .revoke(rev_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grant_b(input logic [2:0] r, input logic [2:0] e,
                         input logic [1:0] es);
    req_b = r;
    step();
    chk("b_sel_valid", 32'(sv_b), 32'd1);
    chk("b_sel", 32'(sel_b), 32'(es));
    step();
    chk("b_ack", 32'(ack_b), 32'(e));
    req_b = 3'b000;
    step();
    chk("b_release", 32'(ack_b), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    step();
    step();
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_sel", 32'(sel_a), 32'd0);
    chk("rst_sel_valid", 32'(sv_a), 32'd0);
    chk("rst_revoke", 32'(rev_d), 32'd0);

    // one-step scan from ptr=0 to channel 3
    @(negedge clk);
    rst_n = 1'b1;
    req_c = 4'b1000;
    step();
    step();
    step();
    step();
    chk("la0_ready_ack", 32'(ack_c), 32'd0);
    chk("la0_ready_sel", 32'(sel_c), 32'd3);
    step();
    chk("la0_ack", 32'(ack_c), 32'h8);
    req_c = 4'b0000;
    step();
    chk("la0_release", 32'(ack_c), 32'd0);

    // single request on channel 2
    req_a = 4'b0100;
    step();
    chk("single_ready_ack", 32'(ack_a), 32'd0);
    chk("single_sel_valid", 32'(sv_a), 32'd1);
    chk("single_sel", 32'(sel_a), 32'd2);
    step();
    chk("single_ack", 32'(ack_a), 32'h4);
    step();
    step();
    step();
    chk("single_hold", 32'(ack_a), 32'h4);
    req_a = 4'b0000;
    step();
    chk("single_release", 32'(ack_a), 32'd0);
    chk("single_sv_low", 32'(sv_a), 32'd0);
    // ptr must now be 3: channel 3 beats channel 2
    req_a = 4'b1100;
    step();
    chk("ptr3_sel", 32'(sel_a), 32'd3);
    step();
    chk("ptr3_ack", 32'(ack_a), 32'h8);
    req_a = 4'b0000;
    step();
    chk("ptr3_release", 32'(ack_a), 32'd0);

    // all channels requesting, ptr back at 0
    req_a = 4'hF;
    gap = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      while (ack_a == 4'h0 && gap < 10) begin
        gap++;
        step();
      end
      chk("rr_grant", 32'(ack_a), 32'd1 << order[n]);
      if (n > 0) chk("rr_gap", 32'(gap), 32'd2);
      step();
      chk("rr_hold", 32'(ack_a), 32'd1 << order[n]);
      step();
      req_a[order[n]] = 1'b0;
      step();
      chk("rr_release", 32'(ack_a), 32'd0);
      req_a = (n < 4) ? 4'hF : 4'h0;
      gap = 1;
    end

    // timeout of 4 cycles on channel 1, channel 2 waiting
    req_d = 4'b0110;
    step();
    chk("to_sel", 32'(sel_d), 32'd1);
    step();
    chk("to_ack_c1", 32'(ack_d), 32'h2);
    step();
    chk("to_ack_c2", 32'(ack_d), 32'h2);
    step();
    chk("to_ack_c3", 32'(ack_d), 32'h2);
    step();
    chk("to_ack_c4", 32'(ack_d), 32'h2);
    step();
    chk("to_ack_drop", 32'(ack_d), 32'd0);
    chk("to_revoke", 32'(rev_d), 32'h2);
    chk("to_sv_revoked", 32'(sv_d), 32'd1);
    step();
    chk("to_revoke_pulse", 32'(rev_d), 32'd0);
    step();
    step();
    step();
    chk("to_no_grant", 32'(ack_d), 32'd0);
    req_d = 4'b0100;
    step();
    chk("to_back_scan", 32'(sv_d), 32'd0);
    step();
    chk("to_next_sel", 32'(sel_d), 32'd2);
    step();
    chk("to_next_ack", 32'(ack_d), 32'h4);
    req_d = 4'b0000;
    step();
    chk("to_next_release", 32'(ack_d), 32'd0);

    // release on the timeout edge wins over revoke
    req_d = 4'b1000;
    step();
    step();
    chk("race_ack", 32'(ack_d), 32'h8);
    step();
    step();
    step();
    req_d = 4'b0000;
    step();
    chk("race_ack_low", 32'(ack_d), 32'd0);
    chk("race_no_revoke", 32'(rev_d), 32'd0);
    chk("race_sv_low", 32'(sv_d), 32'd0);

    // N=3 wrap: ptr 2 -> grant 0 -> ptr 1, and release of 2 -> ptr 0
    grant_b(3'b010, 3'b010, 2'd1);
    grant_b(3'b001, 3'b001, 2'd0);
    grant_b(3'b101, 3'b100, 2'd2);
    grant_b(3'b011, 3'b001, 2'd0);

    // asynchronous reset while channel 3 is busy (ptr is 1)
    req_a = 4'b1000;
    step();
    step();
    chk("mid_busy_ack", 32'(ack_a), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack_a), 32'd0);
    chk("arst_revoke", 32'(rev_a), 32'd0);
    chk("arst_sv", 32'(sv_a), 32'd0);
    req_a = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_sel", 32'(sel_a), 32'd0);
    step();
    chk("post_rst_ack", 32'(ack_a), 32'h1);
    req_a = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_token_arbiter.md
# rr_token_arbiter

Parametrised N-channel round-robin arbiter granting one shared resource to N requesters over a four-phase req/ack handshake. It is the next generation of the three-channel token-passing controller/arbiter pair and sits between the client request lines and the shared resource. It adds three things: a configurable channel count, a one-cycle lookahead scan mode, and an optional hold timeout with forced revocation.

## Interface
- N, 4: number of channels; legal range 2..32.
- LOOKAHEAD, 1: scan mode.
  - 1: jump directly to the next requesting channel.
  - 0: advance the token one channel per cycle, as the legacy ring does.
- TIMEOUT, 0: maximum cycles `ack` may stay high per grant; 0 disables the timeout.
- PTR_W, derived: equals max(1, $clog2(N)); not overridable.

Ports (the reset is asynchronous and active-low):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-channel request; the client holds it high until it finishes with the resource.
- ack  out  N  per-channel grant; registered; at most one bit is ever high.
- sel  out  PTR_W  index of the granted or selected channel; valid only when sel_valid=1.
- sel_valid  out  1  high in READY, BUSY and REVOKED.
- revoke  out  N  one-cycle pulse on the channel whose grant was removed by timeout.

## Operation
- State: FSM with states SCAN, READY, BUSY, REVOKED, plus the registers below.
  - ptr[PTR_W-1:0]: token position.
  - g[PTR_W-1:0]: granted index.
  - cnt: width $clog2(TIMEOUT+1), minimum 1.
- Reset: state=SCAN, ptr=0, g=0, cnt=0, ack=0, revoke=0, sel=0, sel_valid=0.
- SCAN, LOOKAHEAD=1:
  - Search for the first i with req[i]=1 in circular order ptr, ptr+1, …, ptr+N-1 (mod N).
  - If found: g=i, go to READY.
  - Otherwise stay in SCAN; ptr is unchanged.
- SCAN, LOOKAHEAD=0:
  - If req[ptr]=1: g=ptr, go to READY.
  - Otherwise ptr=(ptr+1) mod N and stay in SCAN.
- READY: ack[g]=1, cnt=0, go to BUSY. A request drop during READY is ignored, and the grant is still issued.
- BUSY, checked in this order:
  1. req[g]=0: ack[g]=0, ptr=(g+1) mod N, go to SCAN.
  2. TIMEOUT>0 and cnt==TIMEOUT-1: ack[g]=0, revoke[g]=1 for one cycle, go to REVOKED.
  3. Otherwise cnt=cnt+1 (saturating).
- REVOKED: wait for req[g]=0, then ptr=(g+1) mod N and go to SCAN. No other channel is granted while in REVOKED.
- Wrap-around: ptr and the search index wrap N-1 to 0. The "+1" is computed modulo N, never modulo 2^PTR_W, so non-power-of-2 N is legal.
- Requests from non-granted channels during READY, BUSY or REVOKED are only considered at the next SCAN.
- Fairness: after a release, the releasing channel has the lowest priority. With LOOKAHEAD=1, a continuously requesting channel waits for at most N-1 other grants.
- Reset mid-operation: all outputs are immediately 0 (asynchronous) and the state returns to SCAN with ptr=0.

## Timing
- Grant latency: req[i] is sampled high in SCAN at edge k, with i first in search order. The FSM is in READY after edge k and ack[i]=1 after edge k+1, so latency is 2 edges. This matches the legacy controller.
- Release latency: req[g]=0 sampled at edge m in BUSY gives ack[g]=0 after edge m. The next SCAN evaluation is at edge m+1, so the earliest next ack comes after edge m+2.
- Back-to-back handover: ack of the old channel falls at least 2 cycles before ack of the new channel rises. There is never overlap or a same-cycle handover.
- Timeout: ack[g] is high for exactly TIMEOUT cycles. revoke[g] is high in the first cycle that ack[g] is low.
- Simultaneous release and timeout: if req[g] drops at the same edge that cnt reaches TIMEOUT-1, the normal release wins and no revoke is issued.
- LOOKAHEAD=0 adds up to N-1 cycles of scan latency per grant.
- sel and sel_valid are registered and change on the same edges as the state.

## Test plan
- Single request, N=4, LOOKAHEAD=1, TIMEOUT=0.
  - Stimulus: req=0100 at edge 1, held 5 cycles, then dropped.
  - Required: ack=0100 from after edge 3; sel=2; ack=0000 one edge after req falls; ptr becomes 3.
- All request, N=4, LOOKAHEAD=1.
  - Stimulus: req=1111; each client drops its request 3 cycles after its ack and re-requests immediately.
  - Required: grant order 0,1,2,3,0; never more than one ack bit high; 2-cycle gap between acks.
- Non-power-of-2 wrap, N=3.
  - Stimulus: hold ptr=2, then req=001.
  - Required: wraps to channel 0; ptr after release is 1, never 3.
- LOOKAHEAD=0, N=4, ptr=0.
  - Stimulus: req=1000.
  - Required: ack[3] rises after 5 edges (3 scan steps plus READY plus BUSY).
- Timeout, TIMEOUT=4.
  - Stimulus: req[1] held high indefinitely.
  - Required: ack[1] high for exactly 4 cycles; revoke[1] one-cycle pulse; no grant to req[2] until req[1] drops; then channel 2 is granted.
- Reset mid-BUSY.
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Required: ack, revoke and sel_valid go to 0 immediately; after release, the first grant goes to the lowest requesting index starting from 0.
